dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache that responds to the LSU's dcache_* request interface.
- Hits complete combinationally in the same cycle. Misses stall the requester (dcache_hit low) while an FSM writes back a dirty victim and refills the line word-by-word over a simple req/ready memory port.
- Sits between the LSU and the unified memory model.

Parameters:
- NUM_SETS, 64, number of lines; power of 2, >=2.
- LINE_WORDS, 4, 32-bit words per line; power of 2, >=2.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- dcache_addr  input  32  byte address from LSU; bits [1:0] ignored.
- dcache_wdata  input  32  store data.
- dcache_re  input  1  load request.
- dcache_we  input  1  store request.
- dcache_rdata  output  32  load data, valid when dcache_hit and dcache_re.
- dcache_hit  output  1  access completes this cycle.
- mem_req  output  1  memory beat request.
- mem_we  output  1  1 = write beat, 0 = read beat.
- mem_addr  output  32  word-aligned beat address.
- mem_wdata  output  32  write-beat data.
- mem_rdata  input  32  read-beat data, valid when mem_ready.
- mem_ready  input  1  beat accepted/completed this cycle.

Behaviour:
- Address split: [1:0] ignored; word = next log2(LINE_WORDS) bits; index = next log2(NUM_SETS) bits; tag = remaining upper bits.
- Storage: valid/dirty bit per set, tag array, data array. Only valid and dirty are reset.
- FSM states: IDLE, WRITEBACK, REFILL. Beat counter is log2(LINE_WORDS) bits wide and wraps to 0 after the last beat.
- Request = re | we. If both are asserted, we has priority (treated as a store).
- IDLE hit (valid[index] && tag match && request):
  - dcache_hit=1 combinationally.
  - Load: dcache_rdata = data[index][word] in the same cycle.
  - Store: the word is written and dirty[index] set at the next posedge.
- IDLE miss:
  - dcache_hit=0.
  - At posedge, latch miss_addr; beat counter <= 0.
  - If valid && dirty, go to WRITEBACK; else go to REFILL.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr = {victim_tag, index, beat, 2'b00}, mem_wdata = data[index][beat].
  - On mem_ready, beat++.
  - Last beat with mem_ready: dirty <= 0, beat <= 0, go to REFILL.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = {miss_tag, index, beat, 2'b00}.
  - On mem_ready, data[index][beat] <= mem_rdata, beat++.
  - Last beat: valid <= 1, tag <= miss_tag, dirty <= 0, go to IDLE.
- After the miss completes, the held request hits one cycle later. Miss latency = beats + stall + 1 cycle.
- Outside IDLE: dcache_hit=0 and array writes from the LSU side are blocked, regardless of request changes.
- If the requester drops or changes its request mid-miss (e.g. LSQ flush), the fill still completes and installs the line. No abort.
- mem_req and mem_addr stay stable until mem_ready. mem_ready while mem_req=0 is ignored.
- No request in IDLE: all outputs 0 except dcache_rdata, which is don't-care (driven 0).
- Reset (including mid-miss): state=IDLE, beat=0, all valid/dirty=0, dcache_hit=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, dcache_rdata=0. Any in-flight beat is abandoned immediately.

Optional Feature:
- Macro DCACHE_PERF_EN.
- When defined, adds outputs:
  - perf_hits (32): increments once per cycle with dcache_hit=1.
  - perf_misses (32): increments once per IDLE->WRITEBACK/REFILL transition.
  - perf_writebacks (32): increments on each WRITEBACK entry.
- Counters wrap at 2^32 and reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg holds:
  - cache_state_t enum (IDLE, WRITEBACK, REFILL);
  - localparam functions for OFFSET_W, INDEX_W, TAG_W;
  - the address-split helper.
- One sub-module, dcache_data_array: NUM_SETS x LINE_WORDS word storage, combinational read port, one synchronous write port; no reset.
- Tags, valid/dirty bits and the FSM stay in dcache_ctrl.

Test Plan:
- Cold load 0x0000_0100, re held, memory returns 0xA0..0xA3 for beats with mem_ready every cycle -> 4 REFILL beats at 0x100, 0x104, 0x108, 0x10C; then dcache_hit=1, dcache_rdata=0xA0.
- Store 0xDEADBEEF to 0x104 after the fill -> hit in the same cycle, no mem_req; a following load of 0x104 returns 0xDEADBEEF.
- Load 0x0000_1100 (same index, new tag) with the line dirty -> 4 write beats to 0x100..0x10C carrying 0xA0, 0xDEADBEEF, 0xA2, 0xA3, then 4 read beats from 0x1100..0x110C, then hit.
- mem_ready asserted only every 3rd cycle -> mem_addr/mem_wdata stable across stall cycles; beat count stays exactly 4 per phase.
- rst pulsed during refill beat 2 -> mem_req=0 immediately; a later load of the same address misses again and refills from beat 0.
- With DCACHE_PERF_EN, run 3 cold misses (one dirty) and 5 hits -> perf_misses=3, perf_writebacks=1, perf_hits counts 5 plus the 3 post-fill hit cycles = 8.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the direct-mapped write-back data cache.
// No logic of its own; no latency.
// No flow control at this level.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } cache_state_t;

  function automatic int offset_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int num_sets, input int line_words);
    return 30 - $clog2(line_words) - $clog2(num_sets);
  endfunction

  // Byte address layout: {tag, index, word, 2'b00}
  function automatic logic [31:0] addr_word(input logic [31:0] addr, input int num_sets,
                                            input int line_words);
    return (addr >> 2) & 32'(line_words - 1);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int num_sets,
                                             input int line_words);
    return (addr >> (2 + offset_w(line_words))) & 32'(num_sets - 1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int num_sets,
                                           input int line_words);
    return addr >> (2 + offset_w(line_words) + index_w(num_sets));
  endfunction

endpackage

// File: rtl/dcache_data_array.sv
// Line data storage: NUM_SETS x LINE_WORDS 32-bit words, unreset.
// Read is combinational; write lands at the next clk edge.
// No backpressure: the write port accepts every cycle wr_en_i is high.
module dcache_data_array
  import dcache_pkg::*;
#(
  parameter int NUM_SETS   = 64,
  parameter int LINE_WORDS = 4,
  localparam int INDEX_W   = index_w(NUM_SETS),
  localparam int OFFSET_W  = offset_w(LINE_WORDS)
) (
  input  logic                clk,
  input  logic [INDEX_W-1:0]  rd_idx_i,
  input  logic [OFFSET_W-1:0] rd_word_i,
  output logic [31:0]         rd_data_o,
  input  logic                wr_en_i,
  input  logic [INDEX_W-1:0]  wr_idx_i,
  input  logic [OFFSET_W-1:0] wr_word_i,
  input  logic [31:0]         wr_data_i
);

  logic [31:0] mem_q [NUM_SETS][LINE_WORDS];

  assign rd_data_o = mem_q[rd_idx_i][rd_word_i];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i][wr_word_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate dcache; DCACHE_PERF_EN adds hit/miss/writeback counters.
// Hits complete in the same cycle; a miss costs writeback beats + refill beats + stalls + 1 cycle.
// Stalls the LSU via dcache_hit=0 during a miss; memory beats hold until mem_ready.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_SETS   = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dcache_addr,
  input  logic [31:0] dcache_wdata,
  input  logic        dcache_re,
  input  logic        dcache_we,
  output logic [31:0] dcache_rdata,
  output logic        dcache_hit,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses,
  output logic [31:0] perf_writebacks
`endif
);

  localparam int OFFSET_W = offset_w(LINE_WORDS);
  localparam int INDEX_W  = index_w(NUM_SETS);
  localparam int TAG_W    = tag_w(NUM_SETS, LINE_WORDS);

  cache_state_t        state_q, state_d;
  logic [OFFSET_W-1:0] beat_q, beat_d;
  logic [INDEX_W-1:0]  miss_idx_q, miss_idx_d;
  logic [TAG_W-1:0]    miss_tag_q, miss_tag_d;
  logic [NUM_SETS-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_q [NUM_SETS];

  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_word;
  logic [TAG_W-1:0]    req_tag;
  logic                req, lookup_hit, last_beat, tag_we;
  logic [INDEX_W-1:0]  rd_idx, wr_idx;
  logic [OFFSET_W-1:0] rd_word, wr_word;
  logic [31:0]         rd_data, wr_data;
  logic                wr_en;

  assign req_idx    = INDEX_W'(addr_index(dcache_addr, NUM_SETS, LINE_WORDS));
  assign req_word   = OFFSET_W'(addr_word(dcache_addr, NUM_SETS, LINE_WORDS));
  assign req_tag    = TAG_W'(addr_tag(dcache_addr, NUM_SETS, LINE_WORDS));
  assign req        = dcache_re | dcache_we;
  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign last_beat  = &beat_q;

  // The single read port serves LSU loads in IDLE and victim beats in WRITEBACK.
  assign rd_idx  = (state_q == IDLE) ? req_idx : miss_idx_q;
  assign rd_word = (state_q == IDLE) ? req_word : beat_q;

  dcache_data_array #(
    .NUM_SETS  (NUM_SETS),
    .LINE_WORDS(LINE_WORDS)
  ) u_data (
    .clk      (clk),
    .rd_idx_i (rd_idx),
    .rd_word_i(rd_word),
    .rd_data_o(rd_data),
    .wr_en_i  (wr_en),
    .wr_idx_i (wr_idx),
    .wr_word_i(wr_word),
    .wr_data_i(wr_data)
  );

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    miss_idx_d   = miss_idx_q;
    miss_tag_d   = miss_tag_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_we       = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = req_idx;
    wr_word      = req_word;
    wr_data      = dcache_wdata;
    dcache_hit   = 1'b0;
    dcache_rdata = 32'h0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = 32'h0;
    mem_wdata    = 32'h0;
    unique case (state_q)
      IDLE: begin
        if (req && lookup_hit) begin
          dcache_hit = 1'b1;
          if (dcache_we) begin
            wr_en            = 1'b1;
            dirty_d[req_idx] = 1'b1;
          end
          if (dcache_re) begin
            dcache_rdata = rd_data;
          end
        end else if (req) begin
          miss_idx_d = req_idx;
          miss_tag_d = req_tag;
          beat_d     = '0;
          state_d    = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[miss_idx_q], miss_idx_q, beat_q, 2'b00};
        mem_wdata = rd_data;
        if (mem_ready) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            dirty_d[miss_idx_q] = 1'b0;
            state_d             = REFILL;
          end
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {miss_tag_q, miss_idx_q, beat_q, 2'b00};
        if (mem_ready) begin
          wr_en   = 1'b1;
          wr_idx  = miss_idx_q;
          wr_word = beat_q;
          wr_data = mem_rdata;
          beat_d  = beat_q + 1'b1;
          if (last_beat) begin
            valid_d[miss_idx_q] = 1'b1;
            dirty_d[miss_idx_q] = 1'b0;
            tag_we              = 1'b1;
            state_d             = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      miss_idx_q <= miss_idx_d;
      miss_tag_q <= miss_tag_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_q[miss_idx_q] <= miss_tag_q;
    end
  end

`ifdef DCACHE_PERF_EN
  logic [31:0] perf_hits_q, perf_misses_q, perf_writebacks_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hits_q       <= '0;
      perf_misses_q     <= '0;
      perf_writebacks_q <= '0;
    end else begin
      if (dcache_hit) perf_hits_q <= perf_hits_q + 32'd1;
      if (state_q == IDLE && state_d != IDLE) perf_misses_q <= perf_misses_q + 32'd1;
      if (state_q == IDLE && state_d == WRITEBACK) perf_writebacks_q <= perf_writebacks_q + 32'd1;
    end
  end

  assign perf_hits       = perf_hits_q;
  assign perf_misses     = perf_misses_q;
  assign perf_writebacks = perf_writebacks_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: expected memory beats and load data are queued by the
// stimulus, and a negedge monitor pops and compares them as the DUT presents them.
module tb_dcache_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] dcache_addr, dcache_wdata, dcache_rdata;
  logic        dcache_re, dcache_we, dcache_hit;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DCACHE_PERF_EN
  logic [31:0] perf_hits, perf_misses, perf_writebacks;
`endif

  dcache_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .dcache_addr (dcache_addr),
    .dcache_wdata(dcache_wdata),
    .dcache_re   (dcache_re),
    .dcache_we   (dcache_we),
    .dcache_rdata(dcache_rdata),
    .dcache_hit  (dcache_hit),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready)
`ifdef DCACHE_PERF_EN
    ,
    .perf_hits      (perf_hits),
    .perf_misses    (perf_misses),
    .perf_writebacks(perf_writebacks)
`endif
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_beats[$];
  logic [31:0] exp_loads[$];
  logic [31:0] mem[0:4095];
  int          checks = 0;
  int          errors = 0;
  int          ready_period = 1;
  int          cyc = 0;
  int          stall_checks = 0;
  bit          chk_en = 1;
  bit          prev_stall = 0;
  logic [31:0] prev_addr, prev_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Memory model: ready pattern and read data settle just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    mem_ready = (ready_period == 1) || ((cyc % ready_period) == 0);
    mem_rdata = mem[mem_addr[13:2]];
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (mem_req && prev_stall) begin
        stall_checks++;
        checks++;
        if (mem_addr !== prev_addr || mem_wdata !== prev_wdata) begin
          errors++;
          $display("FAIL stall_stable: addr %h wdata %h, required addr %h wdata %h",
                   mem_addr, mem_wdata, prev_addr, prev_wdata);
        end
      end
      if (mem_req && mem_ready) begin
        if (mem_we) mem[mem_addr[13:2]] = mem_wdata;
        if (chk_en) begin
          checks++;
          if (exp_beats.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected: we %0b addr %h wdata %h, required no beat",
                     mem_we, mem_addr, mem_wdata);
          end else begin
            beat_t e;
            e = exp_beats.pop_front();
            if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.data)) begin
              errors++;
              $display("FAIL beat: we %0b addr %h wdata %h, required we %0b addr %h wdata %h",
                       mem_we, mem_addr, mem_wdata, e.we, e.addr, e.data);
            end
          end
        end
      end
      prev_stall = mem_req && !mem_ready;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
      if (chk_en && dcache_hit && dcache_re && !dcache_we) begin
        checks++;
        if (exp_loads.size() == 0) begin
          errors++;
          $display("FAIL load_unexpected: rdata %h, required no load", dcache_rdata);
        end else begin
          logic [31:0] e;
          e = exp_loads.pop_front();
          if (dcache_rdata !== e) begin
            errors++;
            $display("FAIL load_data: rdata %h, required %h", dcache_rdata, e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_line(input logic we, input logic [31:0] base, input logic [31:0] d0,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
    exp_beats.push_back('{we, base,         d0});
    exp_beats.push_back('{we, base + 32'h4, d1});
    exp_beats.push_back('{we, base + 32'h8, d2});
    exp_beats.push_back('{we, base + 32'hC, d3});
  endtask

  // Holds the request until a hit; exp_lat < 0 skips the latency comparison.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input int exp_lat, input string name);
    int lat;
    bit got;
    lat = 0;
    got = 0;
    @(posedge clk); #1;
    dcache_re = r; dcache_we = w; dcache_addr = a; dcache_wdata = wd;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dcache_hit) begin
        got = 1;
        break;
      end
      lat++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: no hit after %0d cycles, required a hit", name, lat);
    end else if (exp_lat >= 0 && lat != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: %0d stall cycles, required %0d", name, lat, exp_lat);
    end
    @(posedge clk); #1;
    dcache_re = 0; dcache_we = 0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] exp, input int lat,
                      input string name);
    if (chk_en) exp_loads.push_back(exp);
    access(1'b1, 1'b0, a, 32'h0, lat, name);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input int lat,
                       input string name);
    access(1'b0, 1'b1, a, d, lat, name);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      mem[12'h040 + i] = 32'hA0 + i;
      mem[12'h440 + i] = 32'hB0 + i;
      mem[12'h840 + i] = 32'hC0 + i;
      mem[12'h080 + i] = 32'hD0 + i;
      mem[12'h0C0 + i] = 32'hE0 + i;
    end
    rst = 1; dcache_re = 1; dcache_we = 0; dcache_addr = 32'h100; dcache_wdata = 32'h0;
    mem_ready = 0; mem_rdata = 32'h0;
    #12;
    chk("rst_hit", {31'h0, dcache_hit}, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", dcache_rdata, 32'h0);
`ifdef DCACHE_PERF_EN
    chk("rst_perf_hits", perf_hits, 32'h0);
`endif
    dcache_re = 0;
    rst = 0;

    // Cold miss: four refill beats then the held load hits.
    push_line(1'b0, 32'h100, 0, 0, 0, 0);
    load(32'h100, 32'hA0, 5, "cold_load");
    store(32'h104, 32'hDEADBEEF, 0, "store_hit");
    load(32'h104, 32'hDEADBEEF, 0, "load_after_store");
    chk("no_beats_on_hits", exp_beats.size(), 0);

    // Dirty victim: writeback of the modified line, then refill of the new tag.
    push_line(1'b1, 32'h100, 32'hA0, 32'hDEADBEEF, 32'hA2, 32'hA3);
    push_line(1'b0, 32'h1100, 0, 0, 0, 0);
    load(32'h1100, 32'hB0, 9, "dirty_miss");

    // Slow memory: beats every third cycle, outputs must hold across stalls.
    store(32'h1108, 32'h12345678, 0, "store_1108");
    ready_period = 3;
    push_line(1'b1, 32'h1100, 32'hB0, 32'hB1, 32'h12345678, 32'hB3);
    push_line(1'b0, 32'h2100, 0, 0, 0, 0);
    load(32'h2100, 32'hC0, -1, "slow_miss");
    ready_period = 1;
    checks++;
    if (stall_checks == 0) begin
      errors++;
      $display("FAIL stall_seen: 0 stall cycles observed, required at least 1");
    end
    chk("slow_beats_done", exp_beats.size(), 0);

    // Reset while refill beat 2 is on the bus.
    push_line(1'b0, 32'h200, 0, 0, 0, 0);
    void'(exp_beats.pop_back());
    void'(exp_beats.pop_back());
    @(posedge clk); #1;
    dcache_re = 1; dcache_addr = 32'h200;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (mem_req && mem_addr == 32'h208) begin
        found = 1;
        break;
      end
    end
    chk("beat2_reached", {31'h0, found}, 32'h1);
    rst = 1;
    #1;
    chk("midrst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("midrst_mem_addr", mem_addr, 32'h0);
    chk("midrst_hit", {31'h0, dcache_hit}, 32'h0);
    dcache_re = 0;
    @(posedge clk); #1;
    rst = 0;
    chk("midrst_beats", exp_beats.size(), 0);
    push_line(1'b0, 32'h200, 0, 0, 0, 0);
    load(32'h200, 32'hD0, 5, "reload_after_rst");
    push_line(1'b0, 32'h2100, 0, 0, 0, 0);
    load(32'h2100, 32'hC0, 5, "valid_cleared");

    // Request dropped mid-miss: the fill still completes and installs the line.
    push_line(1'b0, 32'h300, 0, 0, 0, 0);
    @(posedge clk); #1;
    dcache_re = 1; dcache_addr = 32'h300;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dcache_re = 0; dcache_addr = 32'h0;
    repeat (10) @(posedge clk);
    chk("dropped_fill_beats", exp_beats.size(), 0);
    load(32'h30C, 32'hE3, 0, "dropped_fill_hit");

`ifdef DCACHE_PERF_EN
    chk_en = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    load(32'h100, 32'h0, 5, "perf_cold1");
    store(32'h100, 32'h55, 0, "perf_store");
    load(32'h104, 32'h0, 0, "perf_hit1");
    load(32'h1100, 32'h0, 9, "perf_dirty");
    load(32'h1104, 32'h0, 0, "perf_hit2");
    load(32'h1108, 32'h0, 0, "perf_hit3");
    load(32'h200, 32'h0, 5, "perf_cold2");
    load(32'h204, 32'h0, 0, "perf_hit4");
    @(negedge clk);
    chk("perf_misses", perf_misses, 32'd3);
    chk("perf_writebacks", perf_writebacks, 32'd1);
    chk("perf_hits", perf_hits, 32'd8);
    chk_en = 1;
`endif

    repeat (3) @(posedge clk);
    chk("beats_drained", exp_beats.size(), 0);
    chk("loads_drained", exp_loads.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
